lb_status_regs: RTL and testbench

Local-bus slave that sits directly downstream of the Ethernet-to-local-bus bridge in the gigabit transceiver Ethernet designs, in the `gmii_tx_clk` domain. Decodes a small register window: ID, scratch, control outputs, one-shot command pulses, synchronized status, per-channel event counters and an uptime counter. Returns read data at a fixed, parameterized latency matching the bridge's read pipeline.

---
 rtl/lb_status_regs.sv | 141 ++++++++++++++
 tb/tb_lb_status_regs.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lb_status_regs.sv
// Local-bus status/control register window: ID, scratch, control, command pulses,
// synchronized status, two event counters and uptime, read back at fixed latency.
module lb_status_regs #(
  parameter int unsigned        ADDR_W    = 24,
  parameter logic [ADDR_W-1:0]  BASE      = 24'h000010,
  parameter int unsigned        READ_LAT  = 3,
  parameter logic [31:0]        BLOCK_ID  = 32'h4C425352,
  parameter logic [7:0]         CTRL_INIT = 8'h00
) (
  input  logic              lb_clk,
  input  logic              lb_rst_n,
  input  logic              lb_valid,
  input  logic              lb_rnw,
  input  logic [ADDR_W-1:0] lb_addr,
  input  logic [31:0]       lb_wdata,
  output logic [31:0]       lb_rdata,
  output logic              lb_rvalid,
  input  logic [15:0]       status_in,
  input  logic [1:0]        ev_in,
  output logic [7:0]        ctrl_out,
  output logic [3:0]        cmd_pulse
);

  logic       hit;
  logic [3:0] offset;
  logic       wr_en;
  logic       rd_en;
  logic [31:0] rd_data;
  logic [1:0]  ev_rise;

  logic [31:0] scratch_q, scratch_d;
  logic [7:0]  ctrl_q, ctrl_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [15:0] status_meta_q, status_meta_d;
  logic [15:0] status_sync_q, status_sync_d;
  logic [1:0]  ev_q, ev_d;
  logic [31:0] cnt0_q, cnt0_d;
  logic [31:0] cnt1_q, cnt1_d;
  logic [31:0] uptime_q, uptime_d;

  logic [READ_LAT-1:0]       pipe_vld_q, pipe_vld_d;
  logic [READ_LAT-1:0][31:0] pipe_data_q, pipe_data_d;

  always_comb begin
    hit     = (lb_addr[ADDR_W-1:4] == BASE[ADDR_W-1:4]);
    offset  = lb_addr[3:0];
    wr_en   = lb_valid & ~lb_rnw & hit;
    rd_en   = lb_valid & lb_rnw;
    ev_rise = ev_in & ~ev_q;
  end

  // Snapshot of the addressed register as seen during the strobe cycle.
  always_comb begin
    rd_data = 32'h0;
    if (hit) begin
      case (offset)
        4'h0:    rd_data = BLOCK_ID;
        4'h1:    rd_data = scratch_q;
        4'h2:    rd_data = {24'h0, ctrl_q};
        4'h4:    rd_data = {16'h0, status_sync_q};
        4'h5:    rd_data = cnt0_q;
        4'h6:    rd_data = cnt1_q;
        4'h7:    rd_data = uptime_q;
        default: rd_data = 32'h0;
      endcase
    end
  end

  always_comb begin
    scratch_d     = scratch_q;
    ctrl_d        = ctrl_q;
    cmd_d         = 4'h0;
    status_meta_d = status_in;
    status_sync_d = status_meta_q;
    ev_d          = ev_in;
    uptime_d      = uptime_q + 32'd1;
    cnt0_d        = cnt0_q + {31'h0, ev_rise[0]};
    cnt1_d        = cnt1_q + {31'h0, ev_rise[1]};
    if (wr_en) begin
      case (offset)
        4'h1:    scratch_d = lb_wdata;
        4'h2:    ctrl_d    = lb_wdata[7:0];
        4'h3:    cmd_d     = lb_wdata[3:0];
        // Clear wins over the count, but an edge in the same cycle still counts once.
        4'h5:    cnt0_d    = {31'h0, ev_rise[0]};
        4'h6:    cnt1_d    = {31'h0, ev_rise[1]};
        default: ;
      endcase
    end
  end

  // Data stages only load on a valid so the output holds until the next result.
  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_data_d    = pipe_data_q;
    pipe_vld_d[0]  = rd_en;
    if (rd_en) begin
      pipe_data_d[0] = rd_data;
    end
    for (int unsigned i = 1; i < READ_LAT; i++) begin
      pipe_vld_d[i] = pipe_vld_q[i-1];
      if (pipe_vld_q[i-1]) begin
        pipe_data_d[i] = pipe_data_q[i-1];
      end
    end
  end

  always_ff @(posedge lb_clk or negedge lb_rst_n) begin
    if (!lb_rst_n) begin
      scratch_q     <= 32'h0;
      ctrl_q        <= CTRL_INIT;
      cmd_q         <= 4'h0;
      status_meta_q <= 16'h0;
      status_sync_q <= 16'h0;
      ev_q          <= 2'b00;
      cnt0_q        <= 32'h0;
      cnt1_q        <= 32'h0;
      uptime_q      <= 32'h0;
      pipe_vld_q    <= '0;
      pipe_data_q   <= '0;
    end else begin
      scratch_q     <= scratch_d;
      ctrl_q        <= ctrl_d;
      cmd_q         <= cmd_d;
      status_meta_q <= status_meta_d;
      status_sync_q <= status_sync_d;
      ev_q          <= ev_d;
      cnt0_q        <= cnt0_d;
      cnt1_q        <= cnt1_d;
      uptime_q      <= uptime_d;
      pipe_vld_q    <= pipe_vld_d;
      pipe_data_q   <= pipe_data_d;
    end
  end

  assign lb_rdata  = pipe_data_q[READ_LAT-1];
  assign lb_rvalid = pipe_vld_q[READ_LAT-1];
  assign ctrl_out  = ctrl_q;
  assign cmd_pulse = cmd_q;

endmodule

// File: tb/tb_lb_status_regs.sv
// Bench for lb_status_regs: directed scenarios plus random traffic, with a
// reference model feeding a read scoreboard that an independent monitor drains.
module tb_lb_status_regs;

  localparam int unsigned READ_LAT  = 3;
  localparam logic [23:0] BASE      = 24'h000010;
  localparam logic [31:0] BLOCK_ID  = 32'h4C425352;
  localparam logic [7:0]  CTRL_INIT = 8'h3C;

  logic        lb_clk;
  logic        lb_rst_n;
  logic        lb_valid;
  logic        lb_rnw;
  logic [23:0] lb_addr;
  logic [31:0] lb_wdata;
  logic [31:0] lb_rdata;
  logic        lb_rvalid;
  logic [15:0] status_in;
  logic [1:0]  ev_in;
  logic [7:0]  ctrl_out;
  logic [3:0]  cmd_pulse;

  lb_status_regs #(
    .ADDR_W   (24),
    .BASE     (BASE),
    .READ_LAT (READ_LAT),
    .BLOCK_ID (BLOCK_ID),
    .CTRL_INIT(CTRL_INIT)
  ) dut (
    .lb_clk   (lb_clk),
    .lb_rst_n (lb_rst_n),
    .lb_valid (lb_valid),
    .lb_rnw   (lb_rnw),
    .lb_addr  (lb_addr),
    .lb_wdata (lb_wdata),
    .lb_rdata (lb_rdata),
    .lb_rvalid(lb_rvalid),
    .status_in(status_in),
    .ev_in    (ev_in),
    .ctrl_out (ctrl_out),
    .cmd_pulse(cmd_pulse)
  );

  initial lb_clk = 1'b0;
  always #5 lb_clk = ~lb_clk;

  int cyc = 0;
  always @(posedge lb_clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [31:0] scr_m, cnt0_m, cnt1_m, up_m;
  logic [7:0]  ctrl_m;
  logic [3:0]  cmd_m;
  logic [1:0]  ev_prev;
  logic [15:0] st_old, st_new;
  int          st_cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  // Status is visible to a read strobed two or more cycles after the change.
  function automatic logic [31:0] model_read(input logic [3:0] off, input int c);
    case (off)
      4'h0:    return BLOCK_ID;
      4'h1:    return scr_m;
      4'h2:    return {24'h0, ctrl_m};
      4'h4:    return {16'h0, (c >= st_cyc + 2) ? st_new : st_old};
      4'h5:    return cnt0_m;
      4'h6:    return cnt1_m;
      4'h7:    return up_m;
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_status(input logic [15:0] v);
    st_old    = (cyc >= st_cyc + 2) ? st_new : st_old;
    st_new    = v;
    st_cyc    = cyc;
    status_in = v;
  endtask

  task automatic step(input logic v, input logic rnw, input logic [23:0] addr,
                      input logic [31:0] wd, input logic [1:0] ev);
    logic [3:0] off;
    logic       hit;
    logic       wr;
    logic [1:0] rise;
    off  = addr[3:0];
    hit  = (addr[23:4] == BASE[23:4]);
    wr   = v & ~rnw & hit;
    rise = ev & ~ev_prev;
    if (v && rnw) sb_q.push_back('{hit ? model_read(off, cyc) : 32'h0, cyc + int'(READ_LAT)});
    cmd_m = 4'h0;
    if (wr) begin
      case (off)
        4'h1:    scr_m  = wd;
        4'h2:    ctrl_m = wd[7:0];
        4'h3:    cmd_m  = wd[3:0];
        default: ;
      endcase
    end
    cnt0_m  = (wr && off == 4'h5) ? {31'h0, rise[0]} : cnt0_m + {31'h0, rise[0]};
    cnt1_m  = (wr && off == 4'h6) ? {31'h0, rise[1]} : cnt1_m + {31'h0, rise[1]};
    up_m    = up_m + 32'd1;
    ev_prev = ev;
    lb_valid = v;
    lb_rnw   = rnw;
    lb_addr  = addr;
    lb_wdata = wd;
    ev_in    = ev;
    @(posedge lb_clk);
    #1;
    check("cmd_pulse", {28'h0, cmd_pulse}, {28'h0, cmd_m});
    check("ctrl_out", {24'h0, ctrl_out}, {24'h0, ctrl_m});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 32'h0, 2'b00);
  endtask

  task automatic rd(input logic [23:0] addr);
    step(1'b1, 1'b1, addr, 32'h0, 2'b00);
  endtask

  task automatic wr(input logic [23:0] addr, input logic [31:0] wd);
    step(1'b1, 1'b0, addr, wd, 2'b00);
  endtask

  // Asserts reset mid-cycle, checks reset outputs, releases just after an edge.
  task automatic do_reset();
    lb_rst_n = 1'b0;
    lb_valid = 1'b0;
    ev_in    = 2'b00;
    sb_q.delete();
    #1;
    check("rst_rvalid", {31'h0, lb_rvalid}, 32'h0);
    check("rst_ctrl", {24'h0, ctrl_out}, {24'h0, CTRL_INIT});
    repeat (2) @(posedge lb_clk);
    #1;
    check("rst_rdata", lb_rdata, 32'h0);
    check("rst_cmd", {28'h0, cmd_pulse}, 32'h0);
    scr_m   = 32'h0;
    cnt0_m  = 32'h0;
    cnt1_m  = 32'h0;
    up_m    = 32'h0;
    ctrl_m  = CTRL_INIT;
    cmd_m   = 4'h0;
    ev_prev = 2'b00;
    st_old  = 16'h0;
    st_new  = status_in;
    st_cyc  = cyc;
    lb_rst_n = 1'b1;
  endtask

  always @(negedge lb_clk) begin
    if (lb_rst_n) begin
      if (lb_rvalid) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_rvalid at cycle %0d: got rvalid=1 data %h, expected no read",
                   cyc, lb_rdata);
        end else begin
          mon_e = sb_q.pop_front();
          check("rdata", lb_rdata, mon_e.data);
          check("rvalid_cycle", cyc, mon_e.due);
        end
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missing_rvalid at cycle %0d: got rvalid=0, expected data %h",
                 cyc, sb_q[0].data);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    lb_rst_n  = 1'b0;
    lb_valid  = 1'b0;
    lb_rnw    = 1'b0;
    lb_addr   = 24'h0;
    lb_wdata  = 32'h0;
    status_in = 16'h0;
    ev_in     = 2'b00;
    st_cyc    = 0;
    #12;
    do_reset();

    // ID then uptime back-to-back right after release
    rd(24'h000010);
    rd(24'h000017);
    idle(5);

    // Scratch round trip and a window miss
    wr(24'h000011, 32'hA5A55A5A);
    rd(24'h000011);
    rd(24'h000020);
    idle(4);

    // Command pulse lasts one cycle; register reads 0
    wr(24'h000013, 32'h0000_0009);
    rd(24'h000013);
    idle(4);

    // Five rising edges on ev_in[0], one of them held high for three cycles
    step(1'b0, 1'b0, 24'h0, 32'h0, 2'b01);
    step(1'b0, 1'b0, 24'h0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 24'h0, 32'h0, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 24'h0, 32'h0, 2'b00);
      step(1'b0, 1'b0, 24'h0, 32'h0, 2'b01);
    end
    idle(3);
    rd(24'h000015);
    idle(4);

    // Clear coincident with an edge leaves 1
    step(1'b1, 1'b0, 24'h000015, 32'hFFFF_FFFF, 2'b01);
    idle(3);
    rd(24'h000015);
    idle(4);

    // Wrap from all-ones
    force dut.cnt0_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt0_q;
    cnt0_m = 32'hFFFF_FFFF;
    step(1'b0, 1'b0, 24'h0, 32'h0, 2'b01);
    idle(3);
    rd(24'h000015);
    rd(24'h000016);
    idle(4);

    // Status synchronizer latency
    set_status(16'h8001);
    idle(1);
    rd(24'h000014);
    idle(1);
    rd(24'h000014);
    idle(4);

    // Reset one cycle after a read strobe drops the read
    wr(24'h000012, 32'h0000_00A7);
    wr(24'h000011, 32'h1234_5678);
    rd(24'h000012);
    rd(24'h000011);
    do_reset();
    idle(6);
    rd(24'h000011);
    rd(24'h000012);
    idle(4);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [23:0] a;
      if (i % 50 == 25) set_status(16'($urandom));
      if ($urandom_range(0, 4) != 0) a = {BASE[23:4], 4'($urandom_range(0, 15))};
      else a = 24'($urandom);
      step($urandom_range(0, 3) != 0, 1'($urandom), a, $urandom, 2'($urandom_range(0, 3)));
    end
    idle(int'(READ_LAT) + 3);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
